// File: rtl/iic_responder.sv
// I2C target: synchronizes filtered SCL/SDA, decodes START/STOP, matches DEV_ADDR
// and maps bus accesses onto a byte-wide register port with an auto-incrementing pointer.
module iic_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       Sysclk,
  input  logic       Rst,
  input  logic       Scl_in,
  input  logic       Sda_in,
  output logic       Sda_out,
  output logic       Sda_t,
  output logic [7:0] Reg_addr,
  output logic [7:0] Reg_wdata,
  output logic       Reg_we,
  output logic       Reg_rd,
  input  logic [7:0] Reg_rdata,
  output logic       Busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [BYTE_W-1:0] shift, shift_nxt;
  logic [BYTE_W-1:0] byte_in_c;
  logic              byte_done, done_nxt;
  logic              rw, rw_nxt;
  logic              rd_d;
  logic              sda_t_nxt, we_nxt, rd_nxt, busy_nxt;
  logic [BYTE_W-1:0] addr_nxt, wdata_nxt;

  assign Sda_out   = 1'b0;
  assign byte_in_c = {shift[BYTE_W-2:0], sda_h};

  // Synchronizers, history and registered edge/START/STOP pulses (bus idles high)
  always_ff @(posedge Sysclk) begin
    if (Rst) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_h     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_h     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_s1    <= Scl_in;
      scl_s2    <= scl_s1;
      scl_h     <= scl_s2;
      sda_s1    <= Sda_in;
      sda_s2    <= sda_s1;
      sda_h     <= sda_s2;
      scl_rise  <= scl_s2 & ~scl_h;
      scl_fall  <= ~scl_s2 & scl_h;
      start_det <= scl_s2 & scl_h & sda_h & ~sda_s2;
      stop_det  <= scl_s2 & scl_h & ~sda_h & sda_s2;
    end
  end

  // State and output registers
  always_ff @(posedge Sysclk) begin
    if (Rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      rd_d      <= 1'b0;
      Sda_t     <= 1'b1;
      Reg_addr  <= '0;
      Reg_wdata <= '0;
      Reg_we    <= 1'b0;
      Reg_rd    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift     <= shift_nxt;
      byte_done <= done_nxt;
      rw        <= rw_nxt;
      rd_d      <= Reg_rd;
      Sda_t     <= sda_t_nxt;
      Reg_addr  <= addr_nxt;
      Reg_wdata <= wdata_nxt;
      Reg_we    <= we_nxt;
      Reg_rd    <= rd_nxt;
      Busy      <= busy_nxt;
    end
  end

  // Next-state and output decode; START/STOP override all bit handling
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift;
    done_nxt  = byte_done;
    rw_nxt    = rw;
    sda_t_nxt = Sda_t;
    addr_nxt  = Reg_addr;
    wdata_nxt = Reg_wdata;
    we_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    busy_nxt  = Busy;

    // User data arrives the cycle after the read request
    if (rd_d) shift_nxt = Reg_rdata;

    if (stop_det) begin
      state_nxt = S_IDLE;
      sda_t_nxt = 1'b1;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end else if (start_det) begin
      state_nxt = S_ADDR;
      cnt_nxt   = '0;
      sda_t_nxt = 1'b1;
      done_nxt  = 1'b0;
    end else begin
      unique case (state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_nxt = byte_in_c;
            cnt_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              done_nxt = 1'b1;
              if (state == S_WDATA) begin
                we_nxt    = 1'b1;
                wdata_nxt = byte_in_c;
              end
            end
          end else if (scl_fall && byte_done) begin
            done_nxt = 1'b0;
            if (state == S_ADDR) begin
              if (shift[BYTE_W-1:1] == DEV_ADDR) begin
                sda_t_nxt = 1'b0;
                state_nxt = S_ADDR_ACK;
                busy_nxt  = 1'b1;
                rw_nxt    = shift[0];
              end else begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
              end
            end else if (state == S_PTR) begin
              addr_nxt  = shift;
              sda_t_nxt = 1'b0;
              state_nxt = S_PTR_ACK;
            end else begin
              sda_t_nxt = 1'b0;
              state_nxt = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise && rw) begin
            rd_nxt = 1'b1;
          end else if (scl_fall) begin
            if (rw) begin
              state_nxt = S_RDATA;
              sda_t_nxt = shift[BYTE_W-1];
              shift_nxt = {shift[BYTE_W-2:0], 1'b0};
              cnt_nxt   = 3'd1;
            end else begin
              sda_t_nxt = 1'b1;
              state_nxt = S_PTR;
            end
          end
        end
        S_PTR_ACK: begin
          if (scl_fall) begin
            sda_t_nxt = 1'b1;
            state_nxt = S_WDATA;
          end
        end
        S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_t_nxt = 1'b1;
            addr_nxt  = Reg_addr + 8'd1;
            state_nxt = S_WDATA;
          end
        end
        S_RDATA: begin
          // bit_cnt wraps to 0 once all 8 bits have been put on the bus
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_t_nxt = 1'b1;
              state_nxt = S_RDATA_ACK;
            end else begin
              sda_t_nxt = shift[BYTE_W-1];
              shift_nxt = {shift[BYTE_W-2:0], 1'b0};
              cnt_nxt   = bit_cnt + 3'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_h) begin
              addr_nxt = Reg_addr + 8'd1;
              rd_nxt   = 1'b1;
              done_nxt = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end else if (scl_fall && byte_done) begin
            done_nxt  = 1'b0;
            state_nxt = S_RDATA;
            sda_t_nxt = shift[BYTE_W-1];
            shift_nxt = {shift[BYTE_W-2:0], 1'b0};
            cnt_nxt   = 3'd1;
          end
        end
        S_IDLE: ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_responder.sv
// Bench for iic_responder: a bit-level bus master, a registered user register file,
// and a transaction-level scoreboard of expected writes, reads and ACKs.
module tb_iic_responder;

  logic       Sysclk = 1'b0;
  logic       Rst;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       Sda_out, Sda_t;
  logic [7:0] Reg_addr, Reg_wdata, Reg_rdata;
  logic       Reg_we, Reg_rd, Busy;

  always #5 Sysclk = ~Sysclk;

  // Wired-AND bus: target pulls low only when its tristate is enabled
  assign sda_bus = sda_m & (Sda_t | Sda_out);

  iic_responder #(.DEV_ADDR(7'h50)) dut (
    .Sysclk   (Sysclk),
    .Rst      (Rst),
    .Scl_in   (scl),
    .Sda_in   (sda_bus),
    .Sda_out  (Sda_out),
    .Sda_t    (Sda_t),
    .Reg_addr (Reg_addr),
    .Reg_wdata(Reg_wdata),
    .Reg_we   (Reg_we),
    .Reg_rd   (Reg_rd),
    .Reg_rdata(Reg_rdata),
    .Busy     (Busy)
  );

  // User register file answering one cycle after a read request
  logic [7:0] umem [256];
  always @(posedge Sysclk) if (Reg_rd) Reg_rdata <= umem[Reg_addr];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] exp_w [$];
  logic [7:0]  exp_r [$];
  bit          quiet = 1'b0;
  logic [15:0] ew;
  logic [7:0]  er;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of strobes against the scoreboard
  always @(negedge Sysclk) begin
    if (!Rst) begin
      check("sda_out_const", 32'(Sda_out), 0);
      if (quiet) check("sda_released", 32'(Sda_t), 1);
      if (Reg_we) begin
        n_checks++;
        if (exp_w.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_we: addr 0x%0h data 0x%0h, no write required", Reg_addr, Reg_wdata);
        end else begin
          ew = exp_w.pop_front();
          check("we_addr", 32'(Reg_addr), 32'(ew[15:8]));
          check("we_data", 32'(Reg_wdata), 32'(ew[7:0]));
        end
      end
      if (Reg_rd) begin
        n_checks++;
        if (exp_r.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd: addr 0x%0h, no read required", Reg_addr);
        end else begin
          er = exp_r.pop_front();
          check("rd_addr", 32'(Reg_addr), 32'(er));
        end
      end
    end
  end

  function automatic bit addr_hit(input logic [7:0] a);
    return a[7:1] == 7'h50;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge Sysclk);
  endtask

  // One SCL period: data set mid-low, sampled mid-high
  task automatic send_bit(input bit b, output bit seen);
    wait_clk(5); sda_m = b;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); seen = sda_bus;
    wait_clk(5); scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl) begin
      wait_clk(5); sda_m = 1'b0;
      wait_clk(5); scl = 1'b0;
    end else begin
      wait_clk(5); sda_m = 1'b1;
      wait_clk(5); scl = 1'b1;
      wait_clk(5); sda_m = 1'b0;
      wait_clk(5); scl = 1'b0;
    end
  endtask

  task automatic bus_stop();
    wait_clk(5); sda_m = 1'b0;
    wait_clk(5); scl = 1'b1;
    wait_clk(5); sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit exp_ack, input string name);
    bit s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    check(name, 32'(s), exp_ack ? 0 : 1);
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] b);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(!ack, s);
  endtask

  task automatic do_write(input logic [7:0] ptr, input logic [7:0] d [4], input int n);
    bus_start();
    write_byte(8'hA0, addr_hit(8'hA0), "w_addr_ack");
    check("busy_after_match", 32'(Busy), 1);
    write_byte(ptr, 1'b1, "w_ptr_ack");
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({8'(ptr + 8'(i)), d[i]});
      write_byte(d[i], 1'b1, "w_data_ack");
    end
    bus_stop();
    check("busy_after_stop", 32'(Busy), 0);
    check("writes_done", 32'(exp_w.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] d [4];
    for (int i = 0; i < 256; i++) umem[i] = 8'h00;
    Rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    check("rst_sda_t", 32'(Sda_t), 1);
    check("rst_addr", 32'(Reg_addr), 0);
    check("rst_wdata", 32'(Reg_wdata), 0);
    check("rst_we", 32'(Reg_we), 0);
    check("rst_rd", 32'(Reg_rd), 0);
    check("rst_busy", 32'(Busy), 0);
    Rst = 1'b0;
    wait_clk(10);

    // Plain write of two bytes
    d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    do_write(8'h10, d, 2);
    check("ptr_after_write", 32'(Reg_addr), 'h12);

    // Combined format: pointer write, repeated START, two-byte read
    umem[8'h20] = 8'h96;
    umem[8'h21] = 8'h3C;
    bus_start();
    write_byte(8'hA0, 1'b1, "cr_addr_ack");
    write_byte(8'h20, 1'b1, "cr_ptr_ack");
    bus_start();
    exp_r.push_back(8'h20);
    exp_r.push_back(8'h21);
    write_byte(8'hA1, addr_hit(8'hA1), "cr_raddr_ack");
    read_byte(1'b1, b);
    check("rd_byte0_model", 32'(b), 32'(umem[8'h20]));
    check("rd_byte0", 32'(b), 'h96);
    read_byte(1'b0, b);
    check("rd_byte1_model", 32'(b), 32'(umem[8'h21]));
    check("rd_byte1", 32'(b), 'h3C);
    check("nack_sda_released", 32'(Sda_t), 1);
    check("nack_busy_held", 32'(Busy), 1);
    bus_stop();
    check("rd_busy_after_stop", 32'(Busy), 0);
    check("reads_done", 32'(exp_r.size()), 0);
    check("ptr_after_read", 32'(Reg_addr), 'h21);

    // Address mismatch: target must stay silent
    quiet = 1'b1;
    bus_start();
    write_byte(8'hA2, addr_hit(8'hA2), "mm_addr_nack");
    check("mm_busy", 32'(Busy), 0);
    write_byte(8'h00, 1'b0, "mm_data_nack");
    bus_stop();
    quiet = 1'b0;
    check("mm_busy_end", 32'(Busy), 0);

    // Pointer wrap
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    do_write(8'hFF, d, 2);
    check("ptr_after_wrap", 32'(Reg_addr), 'h01);

    // Abort after three data bits, then a normal write
    bus_start();
    write_byte(8'hA0, 1'b1, "ab_addr_ack");
    write_byte(8'h40, 1'b1, "ab_ptr_ack");
    begin
      bit s;
      for (int i = 0; i < 3; i++) send_bit(1'b1, s);
    end
    bus_stop();
    check("ab_busy", 32'(Busy), 0);
    check("ab_sda_t", 32'(Sda_t), 1);
    check("ab_ptr", 32'(Reg_addr), 'h40);
    d = '{8'h77, 8'h00, 8'h00, 8'h00};
    do_write(8'h30, d, 1);
    check("ptr_after_abort_write", 32'(Reg_addr), 'h31);

    // Reset while the target drives a 0 data bit
    umem[8'h31] = 8'h0F;
    exp_r.push_back(8'h31);
    bus_start();
    write_byte(8'hA1, 1'b1, "rr_addr_ack");
    wait_clk(6);
    check("rr_bit7_low", 32'(Sda_t), 0);
    Rst = 1'b1;
    @(negedge Sysclk);
    check("rr_sda_t", 32'(Sda_t), 1);
    check("rr_addr", 32'(Reg_addr), 0);
    check("rr_wdata", 32'(Reg_wdata), 0);
    check("rr_we", 32'(Reg_we), 0);
    check("rr_rd", 32'(Reg_rd), 0);
    check("rr_busy", 32'(Busy), 0);
    Rst = 1'b0;
    quiet = 1'b1;
    read_byte(1'b1, b);
    check("rr_bus_idle_byte", 32'(b), 'hFF);
    bus_stop();
    quiet = 1'b0;
    check("rr_reads_done", 32'(exp_r.size()), 0);
    d = '{8'hAB, 8'h00, 8'h00, 8'h00};
    do_write(8'h05, d, 1);
    check("ptr_after_reset_write", 32'(Reg_addr), 'h06);

    wait_clk(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
